// File: rtl/cpu_mem_pkg.sv
// Shared constants and the byte-lane merge helper for the CPU memory responder.
package cpu_mem_pkg;

  localparam logic [3:0]  MMIO_CYCLE   = 4'h8;
  localparam logic [3:0]  MMIO_HALT    = 4'hC;
  localparam logic [31:0] NOP_WORD_DEF = 32'h00000013;
  localparam int          WORD_IDX_W   = 8;

  // Shared by the RAM write path and the store-to-load bypass.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_mmio_regs.sv
// MMIO window registers: free-running cycle counter, sticky halt/exit code, read mux.
module mem_mmio_regs
  import cpu_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  offset,
  input  logic [30:0] exit_wdata,
  input  logic [3:0]  wmask,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        halt,
  output logic [30:0] exit_code
);

  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      // Only the first full-word halt write counts; the exit code is then frozen.
      if (sel && we && offset == MMIO_HALT && wmask == 4'hF && !halt) begin
        halt      <= 1'b1;
        exit_code <= exit_wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        MMIO_CYCLE: rdata = cycle_cnt;
        MMIO_HALT:  rdata = {exit_code, halt};
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Shared fetch/data RAM with 1-cycle registered reads, byte-masked stores and an MMIO window.
// Optional MEM_BYPASS_EN: same-cycle store data is forwarded to both read ports.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int                ADDR_W    = WORD_IDX_W + 2,
  parameter logic [31:0]       NOP_WORD  = NOP_WORD_DEF,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 10'h3F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_rd_en,
  output logic [31:0]       inst_rdata,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wmask,
  input  logic              data_we,
  output logic [31:0]       data_rdata,
  output logic              halt,
  output logic [30:0]       exit_code
);

  localparam int IDX_W = ADDR_W - 2;

  logic [31:0]      mem [2**IDX_W];
  logic [IDX_W-1:0] i_idx;
  logic [IDX_W-1:0] d_idx;
  logic             inst_win;
  logic             data_win;
  logic             store_now;
  logic [31:0]      store_word;
  logic [31:0]      inst_word;
  logic [31:0]      data_word;
  logic [31:0]      mmio_rdata;
  logic             unused_bits;

  assign i_idx      = inst_addr[ADDR_W-1:2];
  assign d_idx      = data_addr[ADDR_W-1:2];
  assign inst_win   = inst_addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4];
  assign data_win   = data_addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4];
  assign store_now  = data_we && !data_win;
  assign store_word = lane_merge(mem[d_idx], data_wdata, data_wmask);
  assign unused_bits = ^{inst_addr[1:0], data_addr[1:0]};

`ifdef MEM_BYPASS_EN
  assign data_word = store_now ? store_word : mem[d_idx];
  assign inst_word = (store_now && i_idx == d_idx) ? store_word : mem[i_idx];
`else
  assign data_word = mem[d_idx];
  assign inst_word = mem[i_idx];
`endif

  // RAM is not reset, but a store must not commit on an edge that sees rst high.
  always_ff @(posedge clk) begin
    if (!rst && store_now) mem[d_idx] <= store_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata <= NOP_WORD;
      data_rdata <= '0;
    end else begin
      if (inst_rd_en) inst_rdata <= inst_win ? NOP_WORD : inst_word;
      data_rdata <= data_win ? mmio_rdata : data_word;
    end
  end

  mem_mmio_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .sel        (data_win),
    .offset     ({data_addr[3:2], 2'b00}),
    .exit_wdata (data_wdata[31:1]),
    .wmask      (data_wmask),
    .we         (data_we),
    .rdata      (mmio_rdata),
    .halt       (halt),
    .exit_code  (exit_code)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder; expectations are hand-computed constants.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  inst_addr;
  logic        inst_rd_en;
  logic [31:0] inst_rdata;
  logic [9:0]  data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wmask;
  logic        data_we;
  logic [31:0] data_rdata;
  logic        halt;
  logic [30:0] exit_code;

  int chk_cnt = 0;
  int err_cnt = 0;
  logic [31:0] v1, v2;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .inst_addr  (inst_addr),
    .inst_rd_en (inst_rd_en),
    .inst_rdata (inst_rdata),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_wmask (data_wmask),
    .data_we    (data_we),
    .data_rdata (data_rdata),
    .halt       (halt),
    .exit_code  (exit_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    data_addr = a; data_wdata = d; data_wmask = m; data_we = 1'b1;
    step();
    data_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; inst_addr = '0; inst_rd_en = 1'b0;
    data_addr = '0; data_wdata = '0; data_wmask = '0; data_we = 1'b0;
    #2 rst = 1'b1;
    step(); step();
    check("rst_inst", inst_rdata, 32'h00000013);
    check("rst_data", data_rdata, 32'h0);
    check("rst_halt", {31'd0, halt}, 32'h0);
    check("rst_exit", {1'b0, exit_code}, 32'h0);

    rst = 1'b0;
    store(10'h000, 32'h00500093, 4'hF);
    check("fetch_hold_nop", inst_rdata, 32'h00000013);

    rst = 1'b1; inst_rd_en = 1'b1; inst_addr = 10'h000;
    step();
    check("fetch_in_rst", inst_rdata, 32'h00000013);
    rst = 1'b0;
    step();
    check("fetch_first", inst_rdata, 32'h00500093);

    store(10'h010, 32'h11223344, 4'hF);
    store(10'h010, 32'hAABBCCDD, 4'b0101);
    data_addr = 10'h010;
    step();
    check("lane_merge", data_rdata, 32'h11BB33DD);
    store(10'h010, 32'hFFFFFFFF, 4'h0);
    step();
    check("mask0_noop", data_rdata, 32'h11BB33DD);
    store(10'h013, 32'h55667788, 4'b1000);
`ifdef MEM_BYPASS_EN
    check("data_same_cycle", data_rdata, 32'h55BB33DD);
`else
    check("data_same_cycle", data_rdata, 32'h11BB33DD);
`endif
    step();
    check("data_after_store", data_rdata, 32'h55BB33DD);

    store(10'h020, 32'h01234567, 4'hF);
    inst_addr = 10'h022;
    store(10'h020, 32'hDEADBEEF, 4'hF);
`ifdef MEM_BYPASS_EN
    check("fetch_same_cycle", inst_rdata, 32'hDEADBEEF);
`else
    check("fetch_same_cycle", inst_rdata, 32'h01234567);
`endif
    step();
    check("fetch_after_store", inst_rdata, 32'hDEADBEEF);

    inst_rd_en = 1'b0;
    inst_addr = 10'h000; step(); check("stall_0", inst_rdata, 32'hDEADBEEF);
    inst_addr = 10'h010; step(); check("stall_1", inst_rdata, 32'hDEADBEEF);
    inst_addr = 10'h004; step(); check("stall_2", inst_rdata, 32'hDEADBEEF);

    inst_rd_en = 1'b1; inst_addr = 10'h3F8;
    step();
    check("fetch_mmio_nop", inst_rdata, 32'h00000013);

    data_addr = 10'h3F8;
    step(); v1 = data_rdata;
    repeat (5) step();
    v2 = data_rdata;
    check("cycle_delta5", v2 - v1, 32'd5);

    @(negedge clk);
    force dut.u_regs.cycle_cnt = 32'hFFFFFFFF;
    #1 release dut.u_regs.cycle_cnt;
    step();
    check("cycle_max", data_rdata, 32'hFFFFFFFF);
    step();
    check("cycle_wrap", data_rdata, 32'h00000000);

    store(10'h3FC, 32'h0000002B, 4'h7);
    check("halt_partial_mask", {31'd0, halt}, 32'h0);
    store(10'h3FC, 32'h0000002B, 4'hF);
    check("halt_set", {31'd0, halt}, 32'h1);
    check("exit_code", {1'b0, exit_code}, 32'h15);
    step();
    check("halt_reg_read", data_rdata, 32'h0000002B);
    store(10'h3FC, 32'h00000008, 4'hF);
    check("exit_sticky", {1'b0, exit_code}, 32'h15);
    check("halt_sticky", {31'd0, halt}, 32'h1);

    data_addr = 10'h010; data_wdata = 32'hFFFFFFFF; data_wmask = 4'hF; data_we = 1'b1;
    rst = 1'b1;
    #1;
    check("async_halt", {31'd0, halt}, 32'h0);
    check("async_exit", {1'b0, exit_code}, 32'h0);
    check("async_inst", inst_rdata, 32'h00000013);
    step();
    data_we = 1'b0;
    data_addr = 10'h3F8;
    rst = 1'b0;
    step();
    check("cycle_after_rst", data_rdata, 32'h0);
    data_addr = 10'h010;
    step();
    check("no_write_in_rst", data_rdata, 32'h55BB33DD);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
